// File: rtl/div_sched_pkg.sv
// Shared execute-stage definitions for the divide scheduler: default width and FSM encoding.
package div_sched_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_state_e;

  // True while the shared divider holds work that a flush must cancel.
  function automatic logic div_in_flight(input div_state_e s);
    return (s == ST_ISSUE) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/div_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the lane granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       aresetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_reg ? 2'b01 : 2'b10;
    end
  end

  // Pointer starts at lane 1 so lane 0 wins the first contest.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      last_reg <= 1'b1;
    end else if (advance) begin
      last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/div_sched.sv
// Two-lane front end that serialises divide requests onto one shared iterative divider.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req0_sign,
  input  logic             req0_rem,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  input  logic             req1_sign,
  input  logic             req1_rem,
  input  logic             flush,
  output logic             div_en,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_sign,
  output logic             div_flush,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_lane,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);

  div_state_e       state_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             sign_reg;
  logic             rem_reg;
  logic             lane_reg;
  logic [WIDTH-1:0] resp_data_reg;
  logic             div_en_reg;
  logic             resp_valid_reg;
  logic             busy_reg;

  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic             sel_sign;
  logic             sel_rem;

  assign req_valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .aresetn (aresetn),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is also held low while reset is asserted, so no handshake can be seen then.
  assign accept     = aresetn && (state_reg == ST_IDLE) && !flush && (grant != 2'b00);
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];

  assign sel_dividend = grant[1] ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant[1] ? req1_divisor  : req0_divisor;
  assign sel_sign     = grant[1] ? req1_sign     : req0_sign;
  assign sel_rem      = grant[1] ? req1_rem      : req0_rem;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= ST_IDLE;
      dividend_reg   <= '0;
      divisor_reg    <= '0;
      sign_reg       <= 1'b0;
      rem_reg        <= 1'b0;
      lane_reg       <= 1'b0;
      resp_data_reg  <= '0;
      div_en_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      div_en_reg <= 1'b0;
      if (flush) begin
        // Flush outranks done and resp_ready: the pending result is dropped.
        state_reg      <= ST_IDLE;
        resp_valid_reg <= 1'b0;
        resp_data_reg  <= '0;
        busy_reg       <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (accept) begin
              dividend_reg <= sel_dividend;
              divisor_reg  <= sel_divisor;
              sign_reg     <= sel_sign;
              rem_reg      <= sel_rem;
              lane_reg     <= grant[1];
              busy_reg     <= 1'b1;
              if (sel_divisor == '0) begin
                state_reg      <= ST_RESP;
                resp_data_reg  <= '0;
                resp_valid_reg <= 1'b1;
              end else begin
                state_reg  <= ST_ISSUE;
                div_en_reg <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            state_reg <= ST_WAIT;
          end
          ST_WAIT: begin
            if (div_done) begin
              resp_data_reg  <= rem_reg ? div_remainder : div_quotient;
              resp_valid_reg <= 1'b1;
              state_reg      <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (resp_ready) begin
              resp_valid_reg <= 1'b0;
              busy_reg       <= 1'b0;
              state_reg      <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign div_en       = div_en_reg;
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;
  assign div_sign     = sign_reg;
  assign div_flush    = flush && div_in_flight(state_reg);
  assign resp_valid   = resp_valid_reg;
  assign resp_lane    = lane_reg;
  assign resp_data    = resp_data_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural fixed-latency divider.
module tb_div_sched;

  localparam int W        = 32;
  localparam int DIV_LAT  = 4;
  localparam int NORM_LAT = DIV_LAT + 2;

  typedef struct packed {
    logic         lane;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_dividend = '0, req0_divisor = '0, req1_dividend = '0, req1_divisor = '0;
  logic         req0_sign = 1'b0, req0_rem = 1'b0, req1_sign = 1'b0, req1_rem = 1'b0;
  logic         flush = 1'b0;
  logic         div_en, div_sign, div_flush;
  logic [W-1:0] div_dividend, div_divisor;
  logic         model_done, inj_done = 1'b0, div_done_w;
  logic [W-1:0] m_q, m_r, m_a, m_b;
  logic         m_s;
  int           m_cnt;
  logic         resp_valid, resp_ready = 1'b0, resp_lane, busy;
  logic [W-1:0] resp_data;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign div_done_w = model_done | inj_done;

  div_sched #(.WIDTH(W)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_dividend (req0_dividend),
    .req0_divisor  (req0_divisor),
    .req0_sign     (req0_sign),
    .req0_rem      (req0_rem),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_dividend (req1_dividend),
    .req1_divisor  (req1_divisor),
    .req1_sign     (req1_sign),
    .req1_rem      (req1_rem),
    .flush         (flush),
    .div_en        (div_en),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_sign      (div_sign),
    .div_flush     (div_flush),
    .div_done      (div_done_w),
    .div_quotient  (m_q),
    .div_remainder (m_r),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_lane     (resp_lane),
    .resp_data     (resp_data),
    .busy          (busy)
  );

  // Divider stand-in: fixed latency, cancelled by div_flush, reset by aresetn.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      model_done <= 1'b0;
      m_cnt      <= 0;
      m_q        <= '0;
      m_r        <= '0;
      m_a        <= '0;
      m_b        <= '0;
      m_s        <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (div_flush) begin
        m_cnt <= 0;
      end else if (div_en) begin
        m_cnt <= DIV_LAT;
        m_a   <= div_dividend;
        m_b   <= div_divisor;
        m_s   <= div_sign;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          model_done <= 1'b1;
          if (m_s) begin
            m_q <= $signed(m_a) / $signed(m_b);
            m_r <= $signed(m_a) % $signed(m_b);
          end else begin
            m_q <= m_a / m_b;
            m_r <= m_a % m_b;
          end
        end
      end
    end
  end

  task automatic drive_req(input bit lane, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit s, input bit r);
    if (lane) begin
      req1_dividend = a; req1_divisor = b; req1_sign = s; req1_rem = r; req1_valid = 1'b1;
    end else begin
      req0_dividend = a; req0_divisor = b; req0_sign = s; req0_rem = r; req0_valid = 1'b1;
    end
  endtask

  // Waits (bounded) for resp_valid; counts div_en pulses and elapsed cycles on the way.
  task automatic wait_resp(input int max_cyc, output int cyc, output int en_cnt, output bit got);
    cyc = 0; en_cnt = 0; got = 1'b0;
    while (!got && cyc <= max_cyc) begin
      if (div_en === 1'b1) en_cnt++;
      if (resp_valid === 1'b1) got = 1'b1;
      else begin
        @(negedge clk); #1; cyc++;
      end
    end
  endtask

  task automatic handshake();
    $display("resp lane=%0d data=%h", resp_lane, resp_data);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    #12;
    n_cmp++;
    if ({req0_ready, req1_ready, div_en, div_flush, resp_valid, busy, resp_lane} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {req0_ready, req1_ready, div_en, div_flush, resp_valid, busy, resp_lane});
    end
    n_cmp++;
    if ({resp_data, div_dividend, div_divisor, div_sign} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got resp=%h dvd=%h dvs=%h sign=%b expected all 0",
               resp_data, div_dividend, div_divisor, div_sign);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    aresetn = 1'b1;
    #1;
  endtask

  task automatic test_rr();
    int cyc, en; bit got; exp_t e;
    @(negedge clk);
    drive_req(1'b0, 32'd10, 32'd3, 1'b0, 1'b0);
    drive_req(1'b1, -32'sd7, 32'd2, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rr_first_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    sb.push_back('{lane: 1'b0, data: 32'd3});
    @(negedge clk); req0_valid = 1'b0; #1;
    n_cmp++;
    if (req1_ready !== 1'b0) begin
      n_bad++; $display("FAIL rr_busy_ready: got %b expected 0", req1_ready);
    end
    wait_resp(50, cyc, en, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL rr_lane0_timeout: got no resp_valid expected resp_valid=1");
    end else begin
      e = sb.pop_front();
      if ({resp_lane, resp_data} !== e) begin
        n_bad++; $display("FAIL rr_lane0_resp: got lane=%0d data=%h expected lane=%0d data=%h",
                          resp_lane, resp_data, e.lane, e.data);
      end
      handshake();
    end
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rr_second_grant: got %b expected 10", {req1_ready, req0_ready});
    end
    sb.push_back('{lane: 1'b1, data: 32'hFFFF_FFFF});
    @(negedge clk); req1_valid = 1'b0; #1;
    wait_resp(50, cyc, en, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL rr_lane1_timeout: got no resp_valid expected resp_valid=1");
    end else begin
      e = sb.pop_front();
      if ({resp_lane, resp_data} !== e) begin
        n_bad++; $display("FAIL rr_lane1_resp: got lane=%0d data=%h expected lane=%0d data=%h",
                          resp_lane, resp_data, e.lane, e.data);
      end
      handshake();
    end
  endtask

  task automatic test_single();
    int cyc, en; bit got; exp_t e;
    @(negedge clk);
    drive_req(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready});
    end
    sb.push_back('{lane: 1'b0, data: 32'd14});
    @(negedge clk); req0_valid = 1'b0; #1;
    wait_resp(50, cyc, en, got);
    n_cmp++;
    if (!got || en != 1 || cyc != NORM_LAT) begin
      n_bad++; $display("FAIL single_timing: got valid=%0d div_en=%0d lat=%0d expected 1/1/%0d",
                        got, en, cyc, NORM_LAT);
    end
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({resp_lane, resp_data} !== e) begin
        n_bad++; $display("FAIL single_resp: got lane=%0d data=%h expected lane=%0d data=%h",
                          resp_lane, resp_data, e.lane, e.data);
      end
      handshake();
    end
    n_cmp++;
    if ({busy, resp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL single_idle: got busy/valid=%b expected 00", {busy, resp_valid});
    end
  endtask

  task automatic test_div0();
    exp_t e;
    @(negedge clk);
    drive_req(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++; $display("FAIL div0_ready: got %b expected 1", req0_ready);
    end
    sb.push_back('{lane: 1'b0, data: 32'd0});
    @(negedge clk); req0_valid = 1'b0; #1;
    n_cmp++;
    if ({resp_valid, div_en} !== 2'b10) begin
      n_bad++; $display("FAIL div0_latency: got valid/div_en=%b expected 10", {resp_valid, div_en});
    end
    e = sb.pop_front();
    n_cmp++;
    if ({resp_lane, resp_data} !== e) begin
      n_bad++; $display("FAIL div0_resp: got lane=%0d data=%h expected lane=%0d data=%h",
                        resp_lane, resp_data, e.lane, e.data);
    end
    handshake();
    n_cmp++;
    if ({div_en, busy} !== 2'b00) begin
      n_bad++; $display("FAIL div0_after: got div_en/busy=%b expected 00", {div_en, busy});
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1;
    drive_req(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle_block: got ready=%b expected 0", req0_ready);
    end
    @(negedge clk); flush = 1'b0; #1;
    @(negedge clk); req0_valid = 1'b0; #1;
    n_cmp++;
    if (div_en !== 1'b1) begin
      n_bad++; $display("FAIL flush_issue: got div_en=%b expected 1", div_en);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (div_flush !== 1'b0) begin
      n_bad++; $display("FAIL flush_quiet: got div_flush=%b expected 0", div_flush);
    end
    @(negedge clk); flush = 1'b1; #1;
    n_cmp++;
    if (div_flush !== 1'b1) begin
      n_bad++; $display("FAIL flush_div_flush: got %b expected 1", div_flush);
    end
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++;
    if ({busy, resp_valid, div_flush} !== 3'b000) begin
      n_bad++; $display("FAIL flush_idle: got busy/valid/div_flush=%b expected 000",
                        {busy, resp_valid, div_flush});
    end
    inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({busy, resp_valid} !== 2'b00) begin
        n_bad++; $display("FAIL flush_stray_done[%0d]: got busy/valid=%b expected 00",
                          i, {busy, resp_valid});
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_hold();
    int cyc, en; bit got; exp_t e;
    @(negedge clk);
    drive_req(1'b1, 32'd20, 32'd6, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_ready: got %b expected 1", req1_ready);
    end
    sb.push_back('{lane: 1'b1, data: 32'd2});
    @(negedge clk); req1_valid = 1'b0; #1;
    wait_resp(50, cyc, en, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL hold_timeout: got no resp_valid expected resp_valid=1");
    end else begin
      e = sb.pop_front();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        n_cmp++;
        if ({resp_valid, resp_lane, resp_data, req0_ready, req1_ready} !== {1'b1, e, 2'b00}) begin
          n_bad++; $display("FAIL hold_stable[%0d]: got v=%b lane=%0d data=%h rdy=%b%b expected v=1 lane=%0d data=%h rdy=00",
                            i, resp_valid, resp_lane, resp_data, req1_ready, req0_ready, e.lane, e.data);
        end
      end
      $display("resp lane=%0d data=%h", resp_lane, resp_data);
      resp_ready = 1'b1;
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_bad++; $display("FAIL hold_hs_ready: got %b expected 00", {req1_ready, req0_ready});
      end
      @(negedge clk);
      resp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n_cmp++;
      if ({busy, resp_valid} !== 2'b00) begin
        n_bad++; $display("FAIL hold_idle: got busy/valid=%b expected 00", {busy, resp_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, en; bit got; exp_t e;
    @(negedge clk);
    drive_req(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    sb.push_back('{lane: 1'b0, data: 32'd14});
    @(negedge clk); req0_valid = 1'b0; #1;
    @(negedge clk); #1;
    aresetn = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if ({busy, resp_valid, div_en, div_flush, req0_ready, req1_ready, resp_lane} !== 7'b0 ||
        resp_data !== '0 || div_divisor !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got busy=%b v=%b en=%b dvs=%h data=%h expected all 0",
                        busy, resp_valid, div_en, div_divisor, resp_data);
    end
    @(negedge clk); aresetn = 1'b1;
    drive_req(1'b0, 32'd50, 32'd5, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_ready: got %b expected 1", req0_ready);
    end
    sb.push_back('{lane: 1'b0, data: 32'd10});
    @(negedge clk); req0_valid = 1'b0; #1;
    wait_resp(50, cyc, en, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL rst_mid_timeout: got no resp_valid expected resp_valid=1");
    end else begin
      e = sb.pop_front();
      if ({resp_lane, resp_data} !== e) begin
        n_bad++; $display("FAIL rst_mid_resp: got lane=%0d data=%h expected lane=%0d data=%h",
                          resp_lane, resp_data, e.lane, e.data);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_single();
    test_div0();
    test_flush();
    test_hold();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
